// File: rtl/func_unit_ls.sv
// Load/store functional unit: one outstanding memory access per issue,
// with alignment/opcode checks and a response timeout.
`ifndef GPR_SIZE
`define GPR_SIZE 63:0
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 4:0
`endif

package func_unit_ls_pkg;
    typedef enum logic [3:0] {
        FU_OP_NOP  = 4'd0,
        FU_OP_ADD  = 4'd1,
        FU_OP_SUB  = 4'd2,
        FU_OP_LDUR = 4'd8,
        FU_OP_STUR = 4'd9
    } fu_op_t;
endpackage

module func_unit_ls
    import func_unit_ls_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                   in_clk,
    input  logic                   in_rst,
    input  logic                   in_rs_start,
    input  fu_op_t                 in_rs_op,
    input  logic [`GPR_SIZE]       in_rs_val_a,
    input  logic [`GPR_SIZE]       in_rs_val_b,
    input  logic [`ROB_IDX_SIZE]   in_rs_dst_rob_index,
    output logic                   out_rs_ready,
    output logic                   out_mem_req_valid,
    output logic                   out_mem_req_write,
    output logic [`GPR_SIZE]       out_mem_req_addr,
    output logic [`GPR_SIZE]       out_mem_req_wdata,
    input  logic                   in_mem_req_ready,
    input  logic                   in_mem_resp_valid,
    input  logic [`GPR_SIZE]       in_mem_resp_rdata,
    output logic                   out_rob_done,
    output logic [`ROB_IDX_SIZE]   out_rob_dst_rob_index,
    output logic [`GPR_SIZE]       out_rob_value,
    output logic                   out_rob_error
);

    localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [CW-1:0] TMO = CW'(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {
        S_IDLE,
        S_REQ,
        S_WAIT,
        S_DONE
    } state_t;

    state_t                 state_q, state_d;
    logic [CW-1:0]          cnt_q, cnt_d;
    logic                   write_q, write_d;
    logic [`GPR_SIZE]       addr_q, addr_d;
    logic [`GPR_SIZE]       wdata_q, wdata_d;
    logic [`ROB_IDX_SIZE]   rob_q, rob_d;
    logic [`GPR_SIZE]       value_q, value_d;
    logic                   err_q, err_d;
    logic [CW-1:0]          cnt_inc;
    logic                   bad_issue;

    assign cnt_inc = cnt_q + 1'b1;
    assign bad_issue = (in_rs_val_a[2:0] != 3'b000) ||
                       !(in_rs_op inside {FU_OP_LDUR, FU_OP_STUR});

    always_ff @(posedge in_clk) begin
        if (in_rst) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            write_q <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rob_q   <= '0;
            value_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            write_q <= write_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rob_q   <= rob_d;
            value_q <= value_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        write_d = write_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        rob_d   = rob_q;
        value_d = value_q;
        err_d   = err_q;
        unique case (state_q)
            S_IDLE: begin
                if (in_rs_start) begin
                    write_d = (in_rs_op == FU_OP_STUR);
                    addr_d  = in_rs_val_a;
                    wdata_d = in_rs_val_b;
                    rob_d   = in_rs_dst_rob_index;
                    value_d = '0;
                    err_d   = bad_issue;
                    state_d = bad_issue ? S_DONE : S_REQ;
                end
            end
            S_REQ: begin
                if (in_mem_req_ready) begin
                    cnt_d   = '0;
                    state_d = S_WAIT;
                end
            end
            S_WAIT: begin
                cnt_d = cnt_inc;
                // A response arriving on the last allowed cycle wins over timeout
                if (in_mem_resp_valid) begin
                    value_d = write_q ? '0 : in_mem_resp_rdata;
                    err_d   = 1'b0;
                    state_d = S_DONE;
                end else if (cnt_inc == TMO) begin
                    value_d = '0;
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    assign out_rs_ready          = (state_q == S_IDLE);
    assign out_mem_req_valid     = (state_q == S_REQ);
    assign out_mem_req_write     = write_q;
    assign out_mem_req_addr      = addr_q;
    assign out_mem_req_wdata     = wdata_q;
    assign out_rob_done          = (state_q == S_DONE);
    assign out_rob_dst_rob_index = rob_q;
    assign out_rob_value         = value_q;
    assign out_rob_error         = err_q;

endmodule

// File: tb/tb_func_unit_ls.sv
// Scoreboard bench for func_unit_ls: directed load/store/error/timeout
// and reset scenarios, completions checked by an independent monitor.
`ifndef GPR_SIZE
`define GPR_SIZE 63:0
`endif
`ifndef ROB_IDX_SIZE
`define ROB_IDX_SIZE 4:0
`endif

module tb_func_unit_ls;
    import func_unit_ls_pkg::*;

    logic                 in_clk = 1'b0;
    logic                 in_rst;
    logic                 in_rs_start;
    fu_op_t               in_rs_op;
    logic [`GPR_SIZE]     in_rs_val_a;
    logic [`GPR_SIZE]     in_rs_val_b;
    logic [`ROB_IDX_SIZE] in_rs_dst_rob_index;
    logic                 out_rs_ready;
    logic                 out_mem_req_valid;
    logic                 out_mem_req_write;
    logic [`GPR_SIZE]     out_mem_req_addr;
    logic [`GPR_SIZE]     out_mem_req_wdata;
    logic                 in_mem_req_ready;
    logic                 in_mem_resp_valid;
    logic [`GPR_SIZE]     in_mem_resp_rdata;
    logic                 out_rob_done;
    logic [`ROB_IDX_SIZE] out_rob_dst_rob_index;
    logic [`GPR_SIZE]     out_rob_value;
    logic                 out_rob_error;

    func_unit_ls #(.TIMEOUT_CYCLES(16)) dut (
        .in_clk                (in_clk),
        .in_rst                (in_rst),
        .in_rs_start           (in_rs_start),
        .in_rs_op              (in_rs_op),
        .in_rs_val_a           (in_rs_val_a),
        .in_rs_val_b           (in_rs_val_b),
        .in_rs_dst_rob_index   (in_rs_dst_rob_index),
        .out_rs_ready          (out_rs_ready),
        .out_mem_req_valid     (out_mem_req_valid),
        .out_mem_req_write     (out_mem_req_write),
        .out_mem_req_addr      (out_mem_req_addr),
        .out_mem_req_wdata     (out_mem_req_wdata),
        .in_mem_req_ready      (in_mem_req_ready),
        .in_mem_resp_valid     (in_mem_resp_valid),
        .in_mem_resp_rdata     (in_mem_resp_rdata),
        .out_rob_done          (out_rob_done),
        .out_rob_dst_rob_index (out_rob_dst_rob_index),
        .out_rob_value         (out_rob_value),
        .out_rob_error         (out_rob_error)
    );

    always #5 in_clk = ~in_clk;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    always @(posedge in_clk) cyc <= cyc + 1;

    typedef struct {
        logic [4:0]  idx;
        logic [63:0] val;
        logic        err;
        int          cyc;
    } exp_t;

    exp_t sb[$];

    task automatic chk(string name, logic [63:0] act, logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge in_clk);
        #1;
    endtask

    // Issue one op; when push is set, the expected completion is queued
    task automatic issue(fu_op_t op, logic [63:0] a, logic [63:0] b,
                         logic [4:0] rob, logic push, logic [63:0] eval,
                         logic eerr, int lat);
        exp_t e;
        int n;
        n = 0;
        while (!out_rs_ready && n < 50) begin
            tick();
            n++;
        end
        if (!out_rs_ready) chk("issue_ready_timeout", 64'd0, 64'd1);
        in_rs_start         = 1'b1;
        in_rs_op            = op;
        in_rs_val_a         = a;
        in_rs_val_b         = b;
        in_rs_dst_rob_index = rob;
        if (push) begin
            e.idx = rob;
            e.val = eval;
            e.err = eerr;
            e.cyc = cyc + lat;
            sb.push_back(e);
        end
        tick();
        in_rs_start = 1'b0;
    endtask

    always @(negedge in_clk) begin
        exp_t e;
        if (out_rob_done) begin
            if (sb.size() == 0) begin
                chk("unexpected_done", 64'd1, 64'd0);
            end else begin
                e = sb.pop_front();
                chk("rob_index", 64'(out_rob_dst_rob_index), 64'(e.idx));
                chk("rob_value", out_rob_value, e.val);
                chk("rob_error", 64'(out_rob_error), 64'(e.err));
                chk("done_cycle", 64'(cyc), 64'(e.cyc));
            end
        end
    end

    initial begin
        #1000000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        in_rst              = 1'b1;
        in_rs_start         = 1'b0;
        in_rs_op            = FU_OP_NOP;
        in_rs_val_a         = '0;
        in_rs_val_b         = '0;
        in_rs_dst_rob_index = '0;
        in_mem_req_ready    = 1'b0;
        in_mem_resp_valid   = 1'b0;
        in_mem_resp_rdata   = '0;
        tick();
        tick();
        chk("rst_rs_ready", 64'(out_rs_ready), 64'd1);
        chk("rst_req_valid", 64'(out_mem_req_valid), 64'd0);
        chk("rst_done", 64'(out_rob_done), 64'd0);
        chk("rst_error", 64'(out_rob_error), 64'd0);
        chk("rst_value", out_rob_value, 64'd0);
        chk("rst_index", 64'(out_rob_dst_rob_index), 64'd0);
        chk("rst_addr", out_mem_req_addr, 64'd0);
        chk("rst_wdata", out_mem_req_wdata, 64'd0);
        in_rst = 1'b0;
        tick();

        // Load, memory ready at once, response one cycle later
        in_mem_req_ready = 1'b1;
        issue(FU_OP_LDUR, 64'h100, 64'h0, 5'd5, 1'b1, 64'hDEAD, 1'b0, 3);
        chk("ld_req_valid", 64'(out_mem_req_valid), 64'd1);
        chk("ld_req_addr", out_mem_req_addr, 64'h100);
        chk("ld_req_write", 64'(out_mem_req_write), 64'd0);
        chk("ld_rs_busy", 64'(out_rs_ready), 64'd0);
        tick();
        in_mem_resp_valid = 1'b1;
        in_mem_resp_rdata = 64'hDEAD;
        tick();
        in_mem_resp_valid = 1'b0;
        tick();

        // Store with 4 cycles of backpressure; stray responses during REQ
        in_mem_req_ready = 1'b0;
        issue(FU_OP_STUR, 64'h208, 64'd42, 5'd2, 1'b1, 64'h0, 1'b0, 7);
        for (int i = 0; i < 4; i++) begin
            chk("st_hold_valid", 64'(out_mem_req_valid), 64'd1);
            chk("st_hold_addr", out_mem_req_addr, 64'h208);
            chk("st_hold_wdata", out_mem_req_wdata, 64'd42);
            chk("st_hold_write", 64'(out_mem_req_write), 64'd1);
            in_mem_resp_valid = 1'b1;
            in_mem_resp_rdata = 64'h77;
            tick();
        end
        in_mem_resp_valid = 1'b0;
        in_mem_req_ready  = 1'b1;
        chk("st_req_valid", 64'(out_mem_req_valid), 64'd1);
        tick();
        in_mem_resp_valid = 1'b1;
        in_mem_resp_rdata = 64'h99;
        tick();
        in_mem_resp_valid = 1'b0;
        tick();

        // Misaligned load and illegal op complete immediately
        issue(FU_OP_LDUR, 64'h103, 64'h0, 5'd7, 1'b1, 64'h0, 1'b1, 1);
        chk("mis_no_req", 64'(out_mem_req_valid), 64'd0);
        tick();
        issue(FU_OP_ADD, 64'h200, 64'h0, 5'd3, 1'b1, 64'h0, 1'b1, 1);
        chk("ill_no_req", 64'(out_mem_req_valid), 64'd0);
        tick();

        // Lost response: timeout after 16 WAIT cycles
        issue(FU_OP_LDUR, 64'h40, 64'h0, 5'd9, 1'b1, 64'h0, 1'b1, 18);
        repeat (20) tick();

        // Response on the 16th WAIT cycle beats the timeout
        issue(FU_OP_LDUR, 64'h48, 64'h0, 5'd10, 1'b1, 64'hBEEF, 1'b0, 18);
        repeat (16) tick();
        in_mem_resp_valid = 1'b1;
        in_mem_resp_rdata = 64'hBEEF;
        tick();
        in_mem_resp_valid = 1'b0;
        tick();

        // Reset while waiting, then a late response must be ignored
        issue(FU_OP_LDUR, 64'h180, 64'h0, 5'd4, 1'b0, 64'h0, 1'b0, 0);
        tick();
        in_rst = 1'b1;
        tick();
        in_rst = 1'b0;
        chk("mid_rst_rs_ready", 64'(out_rs_ready), 64'd1);
        chk("mid_rst_req_valid", 64'(out_mem_req_valid), 64'd0);
        chk("mid_rst_done", 64'(out_rob_done), 64'd0);
        in_mem_resp_valid = 1'b1;
        in_mem_resp_rdata = 64'hBAD;
        tick();
        in_mem_resp_valid = 1'b0;
        chk("late_resp_done", 64'(out_rob_done), 64'd0);
        chk("late_resp_rs_ready", 64'(out_rs_ready), 64'd1);

        issue(FU_OP_LDUR, 64'h300, 64'h0, 5'd6, 1'b1, 64'h5A5A, 1'b0, 3);
        tick();
        in_mem_resp_valid = 1'b1;
        in_mem_resp_rdata = 64'h5A5A;
        tick();
        in_mem_resp_valid = 1'b0;
        repeat (3) tick();

        chk("scoreboard_empty", 64'(sb.size()), 64'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
